// File: rtl/aes_pkg.sv
// Shared AES definitions: key length encodings, round counts and the
// round-transform helpers used by the encipher datapath.
package aes_pkg;

   localparam logic       AES_128_BIT_KEY    = 1'b0;
   localparam logic       AES_256_BIT_KEY    = 1'b1;
   localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
   localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction

   function automatic logic [31:0] mixw(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gm2(a0) ^ gm3(a1) ^ a2      ^ a3,
              a0      ^ gm2(a1) ^ gm3(a2) ^ a3,
              a0      ^ a1      ^ gm2(a2) ^ gm3(a3),
              gm3(a0) ^ a1      ^ a2      ^ gm2(a3)};
   endfunction

   function automatic logic [127:0] mixcolumns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = mixw(s[127-32*c -: 32]);
      return o;
   endfunction

   // Column-major state: byte 4c+r sits in row r of column c.
   function automatic logic [127:0] shiftrows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] addroundkey(input logic [127:0] s,
                                                input logic [127:0] k);
      return s ^ k;
   endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Round-engine bus: start handshake, key memory read port and the
// shared S-box port.
interface aes_encipher_block_if;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   modport master (
      output next, keylen, round_key, new_sboxw, block,
      input  round, sboxw, new_block, ready
   );

   modport slave (
      input  next, keylen, round_key, new_sboxw, block,
      output round, sboxw, new_block, ready
   );
endinterface

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher: one S-box word per cycle, then a
// combined ShiftRows/MixColumns/AddRoundKey step per round.
module aes_encipher_block
   import aes_pkg::*;
(
   input logic                 clk,
   input logic                 reset_n,
   aes_encipher_block_if.slave bus
);

   typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

   state_t          state;
   logic [3:0][31:0] block_w;
   logic [3:0]      round_ctr;
   logic [1:0]      sword_ctr;
   logic            ready_reg;
   logic [3:0]      num_rounds;

   assign num_rounds = (bus.keylen == AES_256_BIT_KEY) ? AES_256_NUM_ROUNDS
                                                       : AES_128_NUM_ROUNDS;

   // Word 0 is the top word; sword_ctr idles at 0 so word 0 shows outside SBOX.
   assign bus.sboxw     = block_w[2'd3 - sword_ctr];
   assign bus.round     = round_ctr;
   assign bus.new_block = block_w;
   assign bus.ready     = ready_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         block_w   <= '0;
         round_ctr <= '0;
         sword_ctr <= '0;
         ready_reg <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.next) begin
                  ready_reg <= 1'b0;
                  round_ctr <= '0;
                  state     <= INIT;
               end
            end
            INIT: begin
               block_w   <= addroundkey(bus.block, bus.round_key);
               round_ctr <= 4'd1;
               sword_ctr <= '0;
               state     <= SBOX;
            end
            SBOX: begin
               block_w[2'd3 - sword_ctr] <= bus.new_sboxw;
               sword_ctr <= sword_ctr + 2'd1;
               if (sword_ctr == 2'd3)
                  state <= MAIN;
            end
            MAIN: begin
               if (round_ctr < num_rounds) begin
                  block_w   <= addroundkey(mixcolumns(shiftrows(block_w)), bus.round_key);
                  round_ctr <= round_ctr + 4'd1;
                  state     <= SBOX;
               end else begin
                  // Final round skips MixColumns.
                  block_w   <= addroundkey(shiftrows(block_w), bus.round_key);
                  round_ctr <= '0;
                  ready_reg <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Directed FIPS-197 vectors; the bench plays key memory and shared S-box.
module tb_aes_encipher_block;

   logic clk;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   aes_encipher_block_if ifc ();

   aes_encipher_block dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   logic [7:0]   sbox_tab [256];
   logic [127:0] sbox_rows [16];
   logic [127:0] rk_mem [16];
   int           rseq [$];

   assign ifc.round_key = rk_mem[ifc.round];
   assign ifc.new_sboxw = {sbox_tab[ifc.sboxw[31:24]], sbox_tab[ifc.sboxw[23:16]],
                           sbox_tab[ifc.sboxw[15:8]],  sbox_tab[ifc.sboxw[7:0]]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input logic kl);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rcon;
      int nk, nr;
      nk   = kl ? 8 : 4;
      nr   = kl ? 14 : 10;
      rcon = 8'h01;
      for (int i = 0; i < 16; i++) rk_mem[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++)
         rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Start one encryption and count edges until ready rises (edge 0 samples next).
   task automatic run(input string tag, input logic [255:0] key, input logic kl,
                      input logic [127:0] pt, input logic [127:0] ct, input int lat,
                      input logic pulse);
      int e;
      bit done;
      expand(key, kl);
      @(negedge clk);
      ifc.block  = pt;
      ifc.keylen = kl;
      ifc.next   = 1'b1;
      @(posedge clk); #1;
      ifc.next = 1'b0;
      chk({tag, ".busy"}, 128'(ifc.ready), 128'(0));
      rseq.delete();
      rseq.push_back(int'(ifc.round));
      e    = 0;
      done = 1'b0;
      while (!done && e < 200) begin
         @(posedge clk); #1;
         e++;
         if (int'(ifc.round) != rseq[$]) rseq.push_back(int'(ifc.round));
         if (ifc.ready) done = 1'b1;
         else ifc.next = pulse & e[0];
      end
      ifc.next = 1'b0;
      chk({tag, ".lat"}, 128'(e), 128'(lat));
      chk({tag, ".ct"}, ifc.new_block, ct);
   endtask

   localparam logic [255:0] K_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

   initial begin
      sbox_rows = '{
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            sbox_tab[16*r+c] = sbox_rows[r][127-8*c -: 8];
      for (int i = 0; i < 16; i++) rk_mem[i] = '0;

      reset_n    = 1'b0;
      ifc.next   = 1'b0;
      ifc.keylen = 1'b0;
      ifc.block  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.ready", 128'(ifc.ready), 128'(1));
      chk("rst.nb",    ifc.new_block,   128'h0);
      chk("rst.round", 128'(ifc.round), 128'(0));
      @(negedge clk) reset_n = 1'b1;

      run("c1", K_C1, 1'b0, P_C1, C_C1, 51, 1'b0);
      run("b",  K_B,  1'b0, P_B,  C_B,  51, 1'b0);
      run("c3", K_C3, 1'b1, P_C1, C_C3, 71, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("c3.hold.ct",    ifc.new_block,   C_C3);
      chk("c3.hold.ready", 128'(ifc.ready), 128'(1));

      run("pulse", K_C1, 1'b0, P_C1, C_C1, 51, 1'b1);

      // Abort mid-encryption with async reset
      expand(K_C1, 1'b0);
      @(negedge clk);
      ifc.block  = P_C1;
      ifc.keylen = 1'b0;
      ifc.next   = 1'b1;
      @(posedge clk); #1;
      ifc.next = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort.busy", 128'(ifc.ready), 128'(0));
      reset_n = 1'b0;
      #1;
      chk("abort.ready", 128'(ifc.ready), 128'(1));
      chk("abort.nb",    ifc.new_block,   128'h0);
      chk("abort.round", 128'(ifc.round), 128'(0));
      @(negedge clk) reset_n = 1'b1;
      run("rerun", K_C1, 1'b0, P_C1, C_C1, 51, 1'b0);

      // Back-to-back: second start lands on the first idle cycle
      run("b2b.a", K_C1, 1'b0, P_C1, C_C1, 51, 1'b0);
      run("b2b.b", K_B,  1'b0, P_B,  C_B,  51, 1'b0);
      chk("b2b.rlen", 128'(rseq.size()), 128'(12));
      for (int i = 0; i < 12 && i < rseq.size(); i++)
         chk($sformatf("b2b.round%0d", i), 128'(rseq[i]), 128'((i <= 10) ? i : 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_encipher_block.md
Name: aes_encipher_block

Overview:
Iterative AES-128/AES-256 encryption round engine. It sits directly downstream of the round key memory.
- Drives `round`; consumes the combinationally read `round_key`.
- Transforms one 128-bit block per `next` request.
- Processes one 32-bit word per cycle through a single S-box. The top level muxes that S-box between this block and the key memory.

Parameters:
- None configurable. Round counts are fixed localparams: AES_128_NUM_ROUNDS = 10, AES_256_NUM_ROUNDS = 14.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- next  input  1  start encryption of `block`; sampled only in IDLE.
- keylen  input  1  0 = AES-128, 1 = AES-256; must be stable while busy.
- round  output  4  round key index requested from the key memory (= round_ctr_reg).
- round_key  input  128  round key for `round`, valid in the same cycle.
- sboxw  output  32  word presented to the shared S-box.
- new_sboxw  input  32  S-box substituted word, combinational return.
- block  input  128  plaintext, sampled in the INIT cycle.
- new_block  output  128  state register; holds ciphertext when ready = 1.
- ready  output  1  1 = idle, result valid.

Behaviour:
- Reset values: ready = 1, new_block = 0, round = 0, FSM = IDLE, sword_ctr = 0.
- Reset is asynchronous at any time. Asserting it mid-operation aborts the operation and returns these values; no partial result is retained.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - `next` = 1 -> INIT; ready <= 0; round_ctr <= 0.
  - `next` is ignored in all other states.
- INIT (1 cycle):
  - block_reg <= block ^ round_key (round = 0).
  - round_ctr <= 1; sword_ctr <= 0; -> SBOX.
- SBOX (4 cycles):
  - sboxw = block_reg word[sword_ctr]; word 0 = bits [127:96].
  - word[sword_ctr] <= new_sboxw; sword_ctr increments 0..3.
  - At sword_ctr == 3: sword_ctr wraps to 0 -> MAIN.
- MAIN (1 cycle), round r = round_ctr:
  - r < num_rounds: block_reg <= MixColumns(ShiftRows(block_reg)) ^ round_key; round_ctr++; -> SBOX.
  - r == num_rounds (final round, no MixColumns): block_reg <= ShiftRows(block_reg) ^ round_key; ready <= 1; round_ctr <= 0; -> IDLE.
- num_rounds is 10 when keylen = 0, 14 when keylen = 1.
- sboxw is don't-care outside SBOX and is driven to word 0 there.
- Latency, counting the edge that samples `next` as edge 0:
  - ready rises after edge 51 for AES-128 and edge 71 for AES-256.
  - Cycle count is 1 + 1 + 5·Nr.
- new_block changes during operation; it is valid only when ready = 1 and holds until the next start.
- `next` asserted on the same edge ready rises is not seen until the following IDLE cycle. Back-to-back issue therefore costs exactly 1 idle cycle.
- GF(2^8) arithmetic: xtime(b) = {b[6:0],0} ^ (0x1b & {8{b[7]}}).
  - Mix of one column: c0' = 2a0^3a1^a2^a3, rotated for c1'..c3'.
- ShiftRows: row i is rotated left by i bytes. Column-major state with byte 0 = [127:120].

Decomposition:
- Shared package `aes_pkg` holds:
  - keylen encodings AES_128_BIT_KEY / AES_256_BIT_KEY;
  - round-count localparams;
  - functions gm2, gm3, mixw, mixcolumns, shiftrows, addroundkey.
- FSM state encodings stay local to the block.
- No sub-module: the S-box is external and shared through the sboxw/new_sboxw ports.

Test Plan:
- FIPS-197 C.1, keylen = 0: key 000102..0f, block 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises after edge 51.
- FIPS-197 B, keylen = 0: key 2b7e151628aed2a6abf7158809cf4f3c, block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.3, keylen = 1: key 000102..1f, same plaintext as C.1 -> 8ea2b7ca516745bfeafc49904b496089; ready rises after edge 71.
- Pulse `next` repeatedly while busy -> no restart; the result is still 69c4e0d8...c55a at edge 51.
- Assert reset_n = 0 at edge 20 mid-encryption -> ready = 1, new_block = 0 immediately. A fresh `next` then yields the correct vector.
- Back-to-back: issue `next` the cycle after ready rises -> second result correct; round sequence 0,1..10 is observed on the round port.
